// File: rtl/uart_cmd_rx_pkg.sv
// Shared encodings and constants for the UART command receiver.
package uart_cmd_rx_pkg;

  localparam int unsigned CMD_W = 12;

  // The second byte of a command carries only the data nibble; its upper nibble must be this.
  localparam logic [3:0] BYTE1_HI = 4'h0;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } byte_state_e;

  typedef enum logic {
    StWaitHi,
    StWaitLo
  } asm_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchronizer followed by a start/data/stop sampling FSM.
module uart_rx_byte
  import uart_cmd_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       busy,
  output logic       start_det,
  output logic       byte_valid,
  output logic       byte_err,
  output logic [7:0] byte_data
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);

  logic [1:0]      sync_q, sync_d;
  logic            rx_s;
  logic            rx_prev_q;
  byte_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;

  assign sync_d = {sync_q[0], rx};
  assign rx_s   = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      sync_q    <= sync_d;
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    start_det  = 1'b0;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // Edge, not level: a held-low line must return high before a new start is seen.
        if (rx_prev_q && !rx_s) begin
          start_det = 1'b1;
          bit_d     = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == FullLast) begin
          cnt_d      = '0;
          state_d    = StIdle;
          byte_valid = rx_s;
          byte_err   = !rx_s;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign byte_data = shift_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Two-byte UART command receiver: assembles {address, op, data} and times out a missing byte 1.
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [CMD_W-1:0] cmd_buf,
  output logic             new_cmd,
  output logic             frame_err
);

  localparam int unsigned ToLimit = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned ToW     = $clog2(ToLimit);
  localparam logic [ToW-1:0] ToLast = ToW'(ToLimit - 1);

  logic       busy, start_det, byte_valid, byte_err;
  logic [7:0] byte_data;

  asm_state_e       asm_q, asm_d;
  logic [7:0]       hi_q, hi_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             new_cmd_q, new_cmd_d;
  logic             frame_err_q, frame_err_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .busy      (busy),
    .start_det (start_det),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .byte_data (byte_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q       <= StWaitHi;
      hi_q        <= '0;
      to_cnt_q    <= '0;
      cmd_q       <= '0;
      new_cmd_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      hi_q        <= hi_d;
      to_cnt_q    <= to_cnt_d;
      cmd_q       <= cmd_d;
      new_cmd_q   <= new_cmd_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    asm_d       = asm_q;
    hi_d        = hi_q;
    to_cnt_d    = to_cnt_q;
    cmd_d       = cmd_q;
    new_cmd_d   = 1'b0;
    frame_err_d = 1'b0;
    if (byte_err) begin
      frame_err_d = 1'b1;
      asm_d       = StWaitHi;
    end else if (byte_valid) begin
      unique case (asm_q)
        StWaitHi: begin
          hi_d     = byte_data;
          to_cnt_d = '0;
          asm_d    = StWaitLo;
        end
        StWaitLo: begin
          if (byte_data[7:4] == BYTE1_HI) begin
            cmd_d     = {hi_q, byte_data[3:0]};
            new_cmd_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          asm_d = StWaitHi;
        end
        default: asm_d = StWaitHi;
      endcase
    end else if (asm_q == StWaitLo && !busy && !start_det) begin
      // Timer pauses while a byte is in flight; a start bit on the expiry cycle pre-empts it.
      if (to_cnt_q == ToLast) begin
        frame_err_d = 1'b1;
        asm_d       = StWaitHi;
      end else begin
        to_cnt_d = to_cnt_q + ToW'(1);
      end
    end
  end

  assign cmd_buf   = cmd_q;
  assign new_cmd   = new_cmd_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: directed frame scenarios plus randomized command pairs.
module tb_uart_cmd_rx;

  localparam int Cpb    = 16;
  localparam int Tob    = 20;
  localparam int Half   = Cpb / 2;
  localparam int ToCyc  = Cpb * Tob;
  // Cycles from driving the start edge to the stop-bit sample: 2 sync + half bit + 9 bits.
  localparam int StopAt = 2 + Half + 9 * Cpb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [11:0] cmd_buf;
  logic        new_cmd;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_new = 0;
  int n_err = 0;
  int n_both = 0;
  int last_err_cyc = -1;

  logic [11:0] model_cmd;

  uart_cmd_rx #(
    .CLKS_PER_BIT(Cpb),
    .TIMEOUT_BITS(Tob)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .cmd_buf  (cmd_buf),
    .new_cmd  (new_cmd),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (new_cmd) n_new <= n_new + 1;
    if (frame_err) begin
      n_err        <= n_err + 1;
      last_err_cyc <= cyc;
    end
    if (new_cmd && frame_err) n_both <= n_both + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int n);
    @(negedge clk);
    rx = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, output int start_cyc);
    @(negedge clk);
    rx        = 1'b0;
    start_cyc = cyc;
    repeat (Cpb - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(b[i], Cpb);
    drive_bit(stop, Cpb);
    if (!stop) drive_bit(1'b1, 2 * Cpb);
  endtask

  // Sends a well-formed two-byte frame and checks it against the command rule.
  task automatic frame_check(input string name, input logic [7:0] b0, input logic [7:0] b1,
                             input int gap);
    int s, nn, ne;
    logic exp_ok;
    nn = n_new;
    ne = n_err;
    send_byte(b0, 1'b1, s);
    idle(gap);
    send_byte(b1, 1'b1, s);
    idle(4);
    exp_ok = (b1[7:4] == 4'h0);
    if (exp_ok) model_cmd = {b0, b1[3:0]};
    checks++;
    if ((n_new - nn) !== (exp_ok ? 1 : 0)) begin
      errors++;
      $display("FAIL %s new_cmd count got %0d want %0d", name, n_new - nn, exp_ok ? 1 : 0);
    end
    checks++;
    if ((n_err - ne) !== (exp_ok ? 0 : 1)) begin
      errors++;
      $display("FAIL %s frame_err count got %0d want %0d", name, n_err - ne, exp_ok ? 0 : 1);
    end
    checks++;
    if (cmd_buf !== model_cmd) begin
      errors++;
      $display("FAIL %s cmd_buf got %h want %h", name, cmd_buf, model_cmd);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    checks++;
    if (cmd_buf !== 12'h000) begin
      errors++;
      $display("FAIL reset cmd_buf got %h want %h", cmd_buf, 12'h000);
    end
    checks++;
    if (new_cmd !== 1'b0) begin
      errors++;
      $display("FAIL reset new_cmd got %b want 0", new_cmd);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset frame_err got %b want 0", frame_err);
    end
    rst = 1'b0;
    model_cmd = 12'h000;
    idle(5);
  endtask

  task automatic test_basic;
    frame_check("basic_651", 8'h65, 8'h01, 3);
  endtask

  task automatic test_bad_nibble;
    frame_check("bad_nibble", 8'h65, 8'h11, 3);
  endtask

  task automatic test_timeout;
    int s, ne, nn, exp_cyc, diff;
    ne = n_err;
    nn = n_new;
    send_byte(8'h65, 1'b1, s);
    idle(400);
    exp_cyc = s + StopAt + ToCyc;
    diff = last_err_cyc - exp_cyc;
    checks++;
    if ((n_err - ne) !== 1) begin
      errors++;
      $display("FAIL timeout err count got %0d want 1", n_err - ne);
    end
    checks++;
    if (diff < -2 || diff > 2) begin
      errors++;
      $display("FAIL timeout cycle got %0d want %0d", last_err_cyc, exp_cyc);
    end
    checks++;
    if ((n_new - nn) !== 0) begin
      errors++;
      $display("FAIL timeout new_cmd count got %0d want 0", n_new - nn);
    end
    frame_check("after_timeout_63A", 8'h63, 8'h0A, 10);
  endtask

  task automatic test_start_wins;
    int s0, s1, ne, nn, guard;
    ne = n_err;
    nn = n_new;
    send_byte(8'h65, 1'b1, s0);
    guard = 0;
    // Next start edge lands on the synchronized line exactly when the timeout would expire.
    while (cyc < s0 + StopAt + ToCyc - 3 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    send_byte(8'h0A, 1'b1, s1);
    idle(4);
    model_cmd = 12'h65A;
    checks++;
    if ((n_err - ne) !== 0) begin
      errors++;
      $display("FAIL start_wins err count got %0d want 0", n_err - ne);
    end
    checks++;
    if ((n_new - nn) !== 1) begin
      errors++;
      $display("FAIL start_wins new_cmd count got %0d want 1", n_new - nn);
    end
    checks++;
    if (cmd_buf !== model_cmd) begin
      errors++;
      $display("FAIL start_wins cmd_buf got %h want %h", cmd_buf, model_cmd);
    end
  endtask

  task automatic test_glitch;
    int nn, ne;
    nn = n_new;
    ne = n_err;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 200);
    checks++;
    if ((n_new - nn) !== 0 || (n_err - ne) !== 0) begin
      errors++;
      $display("FAIL glitch pulses got new=%0d err=%0d want 0 0", n_new - nn, n_err - ne);
    end
    frame_check("after_glitch_6F3", 8'h6F, 8'h03, 0);
  endtask

  task automatic test_stop_err;
    int s, ne;
    ne = n_err;
    send_byte(8'h42, 1'b0, s);
    checks++;
    if ((n_err - ne) !== 1) begin
      errors++;
      $display("FAIL stop_err err count got %0d want 1", n_err - ne);
    end
    frame_check("after_stop_6A5", 8'h6A, 8'h05, 7);
  endtask

  task automatic test_break;
    int nn, ne;
    nn = n_new;
    ne = n_err;
    drive_bit(1'b0, 400);
    drive_bit(1'b1, 40);
    checks++;
    if ((n_err - ne) !== 1 || (n_new - nn) !== 0) begin
      errors++;
      $display("FAIL break pulses got err=%0d new=%0d want 1 0", n_err - ne, n_new - nn);
    end
    frame_check("after_break_557", 8'h55, 8'h07, 2);
  endtask

  task automatic test_random;
    logic [7:0] b0, b1;
    for (int i = 0; i < 12; i++) begin
      b0 = 8'($urandom);
      if ($urandom_range(0, 1) == 1) b1 = {4'h0, 4'($urandom)};
      else b1 = {4'($urandom_range(1, 15)), 4'($urandom)};
      frame_check("random", b0, b1, int'($urandom_range(0, 60)));
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b0, b1;
    for (int i = 0; i < 4; i++) begin
      b0 = 8'($urandom);
      b1 = {4'h0, 4'($urandom)};
      frame_check("back_to_back", b0, b1, 0);
    end
  endtask

  task automatic test_reset_mid;
    int s, nn, ne;
    logic [7:0] b1;
    b1 = 8'h09;
    nn = n_new;
    ne = n_err;
    send_byte(8'h6C, 1'b1, s);
    drive_bit(1'b0, Cpb);
    for (int i = 0; i < 3; i++) drive_bit(b1[i], Cpb);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(40);
    model_cmd = 12'h000;
    checks++;
    if ((n_new - nn) !== 0 || (n_err - ne) !== 0) begin
      errors++;
      $display("FAIL reset_mid pulses got new=%0d err=%0d want 0 0", n_new - nn, n_err - ne);
    end
    checks++;
    if (cmd_buf !== model_cmd) begin
      errors++;
      $display("FAIL reset_mid cmd_buf got %h want %h", cmd_buf, model_cmd);
    end
    frame_check("after_reset_6C9", 8'h6C, 8'h09, 5);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_nibble();
    test_timeout();
    test_start_wins();
    test_glitch();
    test_stop_err();
    test_break();
    test_random();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (n_both !== 0) begin
      errors++;
      $display("FAIL exclusive_pulses got %0d want 0", n_both);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 4..4095.
REQ-002 SHALL have parameter TIMEOUT_BITS, default 20, bit periods allowed between end of first byte and start bit of second byte.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port cmd_buf  output  12  last valid command {address[4:0], op[2:0], data[3:0]}.
REQ-007 SHALL have port new_cmd  output  1  one-cycle pulse, cmd_buf valid in the same cycle.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on any discarded byte or frame.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use; this adds 2 cycles of input latency.
REQ-010 SHALL run a byte state machine IDLE -> START -> DATA -> STOP -> IDLE.
REQ-011 IDLE: on synchronized rx falling to 0, go to START and clear the bit counter.
REQ-012 START: at CLKS_PER_BIT/2 (integer divide) cycles, sample; if 1 (glitch), return to IDLE with no error; if 0, go to DATA.
REQ-013 DATA: sample every CLKS_PER_BIT cycles (mid-bit); shift LSB first; after the 8th sample, go to STOP.
REQ-014 STOP: sample after CLKS_PER_BIT cycles; if 1, deliver the byte; if 0, pulse frame_err, discard the byte and reset frame assembly; in both cases go to IDLE.
REQ-015 SHALL assemble each command from two bytes: byte 0 = cmd_buf[11:4]; byte 1 upper nibble SHALL be 4'h0, lower nibble = cmd_buf[3:0].
REQ-016 Frame assembler SHALL have states WAIT_HI and WAIT_LO; a delivered byte in WAIT_HI is stored and the state moves to WAIT_LO.
REQ-017 In WAIT_LO, a delivered byte with upper nibble 0 SHALL update cmd_buf and pulse new_cmd on the cycle after the stop sample, then return to WAIT_HI.
REQ-018 In WAIT_LO, a delivered byte with nonzero upper nibble SHALL pulse frame_err, leave cmd_buf unchanged and return to WAIT_HI.
REQ-019 In WAIT_LO, if TIMEOUT_BITS*CLKS_PER_BIT cycles elapse with no start bit, SHALL pulse frame_err and return to WAIT_HI; the timeout counter is cleared on entry to WAIT_LO.
REQ-020 If a start bit is detected on the same cycle the timeout expires, the start bit SHALL win and no timeout error is raised.
REQ-021 cmd_buf SHALL hold its value between commands; new_cmd and frame_err SHALL never assert in the same cycle.
REQ-022 A line held low (break) SHALL produce one frame_err at STOP, then wait in IDLE until rx returns high before accepting a new start bit.
REQ-023 Counters SHALL be sized by $clog2 of their maximum terminal value and SHALL never wrap.

Reset
REQ-024 While rst is high: byte FSM = IDLE, assembler = WAIT_HI, cmd_buf = 12'h000, new_cmd = 0, frame_err = 0, synchronizer = 1, all counters 0.
REQ-025 Reset mid-byte or mid-frame SHALL abort silently with no pulse; the first start bit after release begins a new frame.

Structure
REQ-026 A shared package SHALL hold the byte-FSM and assembler state encodings, CMD_W = 12, and the byte-1 nibble check constant 4'h0.
REQ-027 SHALL instantiate sub-module uart_rx_byte (synchronizer plus byte FSM, outputs byte_valid pulse, byte_data[7:0] and byte_err pulse); frame assembly and timeout live in the top level.

Verification (CLKS_PER_BIT = 16, TIMEOUT_BITS = 20)
REQ-028 Send bytes 0x65 then 0x01 -> one new_cmd pulse, cmd_buf = 12'h651, no frame_err.
REQ-029 Send 0x65, then 0x11 -> frame_err pulse, no new_cmd, cmd_buf keeps its previous value.
REQ-030 Send 0x65, then idle 400 cycles -> frame_err at cycle 320 after the first stop sample; a following 0x63/0x0A frame yields cmd_buf = 12'h63A.
REQ-031 Drive a 5-cycle low glitch on an idle line -> no output pulses; then a valid frame 0x6F/0x03 -> cmd_buf = 12'h6F3.
REQ-032 Drive the stop bit of byte 0 low -> frame_err; next frame 0x6A/0x05 -> cmd_buf = 12'h6A5.
REQ-033 Assert rst mid-byte 1 of a frame -> no pulses, cmd_buf = 12'h000; next frame 0x6C/0x09 -> new_cmd with cmd_buf = 12'h6C9.
